baw_game_ctrl: RTL and testbench

- Parametrised game controller for the Black-and-White card game; second generation of the top-level game FSM.
- Owns the round/turn state machine, per-player remaining-card masks, committed hand cards, match comparison, score and game-end detection.
- Adds button edge detection, selection validation with error flag, a configurable deck size, round limit and win target, and a single score update per round.
- Sits between the board I/O (buttons, switches) and the display/LED renderers, which consume its outputs.

---
 rtl/baw_game_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_baw_game_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baw_game_ctrl.sv
// Black-and-White card game controller.
// Sequences rounds and turns, tracks each player's remaining cards and committed
// hand, scores every round once, and flags the end of the game.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no game running; all outputs at reset values
// ROUND_SHOW | new round announced, waiting for next
// COLOR_SHOW | colour counts shown; players enter pick states or reveal
// P1_PICK    | player 1 choosing a card on the switch bank
// P2_PICK    | player 2 choosing a card on the switch bank
// RESULT     | round outcome shown and scored
// GAME_OVER  | final result held until start or abort
module baw_game_ctrl #(
    parameter int NUM_CARDS  = 9,
    parameter int MAX_ROUNDS = 9,
    parameter int WIN_TARGET = 5,
    localparam int CW = $clog2(NUM_CARDS),
    localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_start,
    input  logic                 btn_abort,
    input  logic                 btn_p1,
    input  logic                 btn_p2,
    input  logic                 btn_confirm,
    input  logic                 btn_next,
    input  logic [NUM_CARDS-1:0] card_sel,
    output logic [2:0]           state,
    output logic [RW-1:0]        round,
    output logic [RW-1:0]        p1_score,
    output logic [RW-1:0]        p2_score,
    output logic [NUM_CARDS-1:0] p1_mask,
    output logic [NUM_CARDS-1:0] p2_mask,
    output logic [CW:0]          p1_black,
    output logic [CW:0]          p1_white,
    output logic [CW:0]          p2_black,
    output logic [CW:0]          p2_white,
    output logic                 p1_hand_black,
    output logic                 p2_hand_black,
    output logic [1:0]           match_result,
    output logic [1:0]           game_result,
    output logic                 sel_error
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ROUND_SHOW = 3'd1,
        S_COLOR_SHOW = 3'd2,
        S_P1_PICK    = 3'd3,
        S_P2_PICK    = 3'd4,
        S_RESULT     = 3'd5,
        S_GAME_OVER  = 3'd6
    } state_t;

    localparam logic [RW-1:0] R_ONE   = RW'(1);
    localparam logic [CW:0]   CNT_ONE = (CW + 1)'(1);

    state_t state_q, state_d;

    logic [5:0] btn_now, btn_q, btn_rise;
    logic ev_abort, ev_start, ev_confirm, ev_next, ev_p1, ev_p2;

    logic [CW-1:0] p1_hand, p2_hand;
    logic          p1_commit, p2_commit;

    logic [CW-1:0] sel_idx;
    logic          sel_onehot, p1_pick_ok, p2_pick_ok;
    logic          finished;
    logic [1:0]    hand_cmp, score_cmp;

    logic do_clear, do_start, do_commit1, do_commit2;
    logic do_result, do_advance, do_finish, sel_err_d;

    // Bit order matches button priority: lowest index wins.
    assign btn_now  = {btn_p2, btn_p1, btn_next, btn_confirm, btn_start, btn_abort};
    assign btn_rise = btn_now & ~btn_q;

    assign ev_abort   = btn_rise[0];
    assign ev_start   = btn_rise[1] & ~btn_rise[0];
    assign ev_confirm = btn_rise[2] & ~(|btn_rise[1:0]);
    assign ev_next    = btn_rise[3] & ~(|btn_rise[2:0]);
    assign ev_p1      = btn_rise[4] & ~(|btn_rise[3:0]);
    assign ev_p2      = btn_rise[5] & ~(|btn_rise[4:0]);

    assign sel_onehot = $onehot(card_sel);
    assign p1_pick_ok = sel_onehot & (|(card_sel & p1_mask));
    assign p2_pick_ok = sel_onehot & (|(card_sel & p2_mask));

    assign finished = (p1_score == RW'(WIN_TARGET)) || (p2_score == RW'(WIN_TARGET)) ||
                      (round == RW'(MAX_ROUNDS));

    assign hand_cmp  = (p1_hand > p2_hand)   ? 2'b01 : (p1_hand < p2_hand)   ? 2'b10 : 2'b11;
    assign score_cmp = (p1_score > p2_score) ? 2'b01 : (p1_score < p2_score) ? 2'b10 : 2'b11;

    // Hand colour is only meaningful once a card is committed.
    assign p1_hand_black = p1_commit & p1_hand[0];
    assign p2_hand_black = p2_commit & p2_hand[0];

    assign state = state_q;

    // Index of the selected switch; only used when the selection is one-hot.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (card_sel[i]) sel_idx = CW'(i);
        end
    end

    // Remaining black (odd) and white (even) card counts per player.
    always_comb begin
        p1_black = '0;
        p1_white = '0;
        p2_black = '0;
        p2_white = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (p1_mask[i]) begin
                if (i % 2 == 1) p1_black = p1_black + CNT_ONE;
                else            p1_white = p1_white + CNT_ONE;
            end
            if (p2_mask[i]) begin
                if (i % 2 == 1) p2_black = p2_black + CNT_ONE;
                else            p2_white = p2_white + CNT_ONE;
            end
        end
    end

    // Button history for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_q <= '0;
        else       btn_q <= btn_now;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and the datapath strobes that accompany each transition.
    always_comb begin
        state_d    = state_q;
        do_clear   = 1'b0;
        do_start   = 1'b0;
        do_commit1 = 1'b0;
        do_commit2 = 1'b0;
        do_result  = 1'b0;
        do_advance = 1'b0;
        do_finish  = 1'b0;
        sel_err_d  = 1'b0;
        if (ev_abort) begin
            state_d  = S_IDLE;
            do_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (ev_start) begin
                        state_d  = S_ROUND_SHOW;
                        do_start = 1'b1;
                    end
                end
                S_ROUND_SHOW: begin
                    if (ev_next) state_d = S_COLOR_SHOW;
                end
                S_COLOR_SHOW: begin
                    if (ev_confirm) begin
                        if (p1_commit && p2_commit) begin
                            state_d   = S_RESULT;
                            do_result = 1'b1;
                        end
                    end else if (ev_p1 && !p1_commit) begin
                        state_d = S_P1_PICK;
                    end else if (ev_p2 && !p2_commit) begin
                        state_d = S_P2_PICK;
                    end
                end
                S_P1_PICK: begin
                    if (ev_confirm) begin
                        if (p1_pick_ok) begin
                            do_commit1 = 1'b1;
                            state_d    = S_COLOR_SHOW;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end else if (ev_next) begin
                        state_d = S_COLOR_SHOW;
                    end
                end
                S_P2_PICK: begin
                    if (ev_confirm) begin
                        if (p2_pick_ok) begin
                            do_commit2 = 1'b1;
                            state_d    = S_COLOR_SHOW;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end else if (ev_next) begin
                        state_d = S_COLOR_SHOW;
                    end
                end
                S_RESULT: begin
                    if (ev_next) begin
                        if (finished) begin
                            state_d   = S_GAME_OVER;
                            do_finish = 1'b1;
                        end else begin
                            state_d    = S_ROUND_SHOW;
                            do_advance = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Game data: round, scores, card masks, hands and results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round        <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            p1_mask      <= '1;
            p2_mask      <= '1;
            p1_hand      <= '0;
            p2_hand      <= '0;
            p1_commit    <= 1'b0;
            p2_commit    <= 1'b0;
            match_result <= 2'b00;
            game_result  <= 2'b00;
            sel_error    <= 1'b0;
        end else begin
            sel_error <= sel_err_d;
            if (do_clear || do_start) begin
                round        <= do_start ? R_ONE : '0;
                p1_score     <= '0;
                p2_score     <= '0;
                p1_mask      <= '1;
                p2_mask      <= '1;
                p1_hand      <= '0;
                p2_hand      <= '0;
                p1_commit    <= 1'b0;
                p2_commit    <= 1'b0;
                match_result <= 2'b00;
                game_result  <= 2'b00;
            end else begin
                if (do_commit1) begin
                    p1_hand   <= sel_idx;
                    p1_mask   <= p1_mask & ~card_sel;
                    p1_commit <= 1'b1;
                end
                if (do_commit2) begin
                    p2_hand   <= sel_idx;
                    p2_mask   <= p2_mask & ~card_sel;
                    p2_commit <= 1'b1;
                end
                if (do_result) begin
                    match_result <= hand_cmp;
                    if (hand_cmp == 2'b01) p1_score <= p1_score + R_ONE;
                    if (hand_cmp == 2'b10) p2_score <= p2_score + R_ONE;
                end
                if (do_advance) begin
                    round        <= round + R_ONE;
                    p1_hand      <= '0;
                    p2_hand      <= '0;
                    p1_commit    <= 1'b0;
                    p2_commit    <= 1'b0;
                    match_result <= 2'b00;
                end
                if (do_finish) game_result <= score_cmp;
            end
        end
    end

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Bench for baw_game_ctrl: directed game scenarios with literal expectations,
// then randomized button/switch traffic, all compared every cycle against a
// behavioural game model.
module tb_baw_game_ctrl;

    localparam int NC = 9;
    localparam int MR = 9;
    localparam int WT = 5;
    localparam int CW = $clog2(NC);
    localparam int RW = $clog2(MR + 1);

    // Button vector order: abort, start, confirm, next, p1, p2 (priority order).
    localparam int B_ABORT = 0, B_START = 1, B_CONFIRM = 2, B_NEXT = 3, B_P1 = 4, B_P2 = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    btns = '0;
    logic [NC-1:0] card_sel = '0;

    logic [2:0]    state;
    logic [RW-1:0] round, p1_score, p2_score;
    logic [NC-1:0] p1_mask, p2_mask;
    logic [CW:0]   p1_black, p1_white, p2_black, p2_white;
    logic          p1_hand_black, p2_hand_black, sel_error;
    logic [1:0]    match_result, game_result;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    baw_game_ctrl #(.NUM_CARDS(NC), .MAX_ROUNDS(MR), .WIN_TARGET(WT)) dut (
        .clk(clk), .reset(rst),
        .btn_start(btns[B_START]), .btn_abort(btns[B_ABORT]),
        .btn_p1(btns[B_P1]), .btn_p2(btns[B_P2]),
        .btn_confirm(btns[B_CONFIRM]), .btn_next(btns[B_NEXT]),
        .card_sel(card_sel),
        .state(state), .round(round), .p1_score(p1_score), .p2_score(p2_score),
        .p1_mask(p1_mask), .p2_mask(p2_mask),
        .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
        .p1_hand_black(p1_hand_black), .p2_hand_black(p2_hand_black),
        .match_result(match_result), .game_result(game_result), .sel_error(sel_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_round, m_s1, m_s2, m_h1, m_h2, m_mr, m_gr;
    bit m_c1, m_c2, m_err;
    bit m_used1[NC];
    bit m_used2[NC];
    bit [5:0] m_prev;

    task automatic m_new_game(input int st);
        m_state = st;
        m_round = (st == 1) ? 1 : 0;
        m_s1 = 0; m_s2 = 0; m_h1 = 0; m_h2 = 0; m_mr = 0; m_gr = 0;
        m_c1 = 0; m_c2 = 0;
        for (int i = 0; i < NC; i++) begin
            m_used1[i] = 0;
            m_used2[i] = 0;
        end
    endtask

    task automatic m_pick(input bit p1);
        int n, idx;
        bit used;
        n = 0; idx = 0;
        for (int i = 0; i < NC; i++) if (card_sel[i]) begin n++; idx = i; end
        used = p1 ? m_used1[idx] : m_used2[idx];
        if (n == 1 && !used) begin
            if (p1) begin m_used1[idx] = 1; m_h1 = idx; m_c1 = 1; end
            else    begin m_used2[idx] = 1; m_h2 = idx; m_c2 = 1; end
            m_state = 2;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic m_step();
        bit [5:0] rise;
        int ev;
        rise = btns & ~m_prev;
        m_prev = btns;
        m_err = 0;
        ev = -1;
        for (int i = 0; i < 6; i++) if (rise[i] && ev < 0) ev = i;
        if (ev == B_ABORT) begin
            m_new_game(0);
        end else begin
            case (m_state)
                0, 6: if (ev == B_START) m_new_game(1);
                1: if (ev == B_NEXT) m_state = 2;
                2: begin
                    if (ev == B_CONFIRM && m_c1 && m_c2) begin
                        m_state = 5;
                        if (m_h1 > m_h2)      begin m_mr = 1; m_s1++; end
                        else if (m_h1 < m_h2) begin m_mr = 2; m_s2++; end
                        else                  m_mr = 3;
                    end else if (ev == B_P1 && !m_c1) m_state = 3;
                    else if (ev == B_P2 && !m_c2) m_state = 4;
                end
                3, 4: begin
                    if (ev == B_CONFIRM) m_pick(m_state == 3);
                    else if (ev == B_NEXT) m_state = 2;
                end
                5: if (ev == B_NEXT) begin
                    if (m_s1 == WT || m_s2 == WT || m_round == MR) begin
                        m_state = 6;
                        m_gr = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
                    end else begin
                        m_state = 1;
                        m_round++;
                        m_c1 = 0; m_c2 = 0; m_h1 = 0; m_h2 = 0; m_mr = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Model advances on the same edges as the DUT, including async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_new_game(0);
            m_err = 0;
            m_prev = '0;
        end else begin
            m_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int em1, em2, b1, w1, b2, w2;
            em1 = 0; em2 = 0; b1 = 0; w1 = 0; b2 = 0; w2 = 0;
            for (int i = 0; i < NC; i++) begin
                if (!m_used1[i]) begin em1 |= (1 << i); if (i % 2 == 1) b1++; else w1++; end
                if (!m_used2[i]) begin em2 |= (1 << i); if (i % 2 == 1) b2++; else w2++; end
            end
            check("m_state", int'(state), m_state);
            check("m_round", int'(round), m_round);
            check("m_p1_score", int'(p1_score), m_s1);
            check("m_p2_score", int'(p2_score), m_s2);
            check("m_p1_mask", int'(p1_mask), em1);
            check("m_p2_mask", int'(p2_mask), em2);
            check("m_p1_black", int'(p1_black), b1);
            check("m_p1_white", int'(p1_white), w1);
            check("m_p2_black", int'(p2_black), b2);
            check("m_p2_white", int'(p2_white), w2);
            check("m_p1_hand_black", int'(p1_hand_black), (m_c1 && (m_h1 % 2 == 1)) ? 1 : 0);
            check("m_p2_hand_black", int'(p2_hand_black), (m_c2 && (m_h2 % 2 == 1)) ? 1 : 0);
            check("m_match_result", int'(match_result), m_mr);
            check("m_game_result", int'(game_result), m_gr);
            check("m_sel_error", int'(sel_error), int'(m_err));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic press(input int b);
        btns[b] = 1'b1;
        @(posedge clk); #1;
        btns[b] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pick(input int player, input int card);
        press(player == 1 ? B_P1 : B_P2);
        card_sel = '0;
        card_sel[card] = 1'b1;
        press(B_CONFIRM);
    endtask

    // Plays a round from ROUND_SHOW up to and including the reveal.
    task automatic play_round(input int c1, input int c2);
        press(B_NEXT);
        pick(1, c1);
        pick(2, c2);
        press(B_CONFIRM);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_round"}, int'(round), 0);
        check({tag, "_p1_score"}, int'(p1_score), 0);
        check({tag, "_p2_score"}, int'(p2_score), 0);
        check({tag, "_p1_mask"}, int'(p1_mask), 'h1FF);
        check({tag, "_p2_mask"}, int'(p2_mask), 'h1FF);
        check({tag, "_match"}, int'(match_result), 0);
        check({tag, "_game"}, int'(game_result), 0);
        check({tag, "_p1_hand_black"}, int'(p1_hand_black), 0);
        check({tag, "_sel_error"}, int'(sel_error), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check_reset_values("reset");

        // Game A: commit behaviour, invalid picks, draw, abort.
        press(B_START);
        check("start_state", int'(state), 1);
        check("start_round", int'(round), 1);
        check("start_mask", int'(p1_mask), 'h1FF);
        check("start_p1_black", int'(p1_black), 4);
        check("start_p1_white", int'(p1_white), 5);
        check("start_scores", int'(p1_score) + int'(p2_score), 0);

        press(B_NEXT);
        check("color_state", int'(state), 2);
        press(B_P1);
        check("p1_pick_state", int'(state), 3);
        card_sel = 9'h080;
        btns[B_CONFIRM] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        btns[B_CONFIRM] = 1'b0;
        @(posedge clk); #1;
        check("held_p1_mask", int'(p1_mask), 'h17F);
        check("held_p1_hand_black", int'(p1_hand_black), 1);
        check("held_p1_black", int'(p1_black), 3);
        check("held_state", int'(state), 2);

        press(B_P2);
        check("p2_pick_state", int'(state), 4);
        card_sel = 9'h003;
        btns[B_CONFIRM] = 1'b1;
        @(posedge clk); #1;
        check("multi_sel_error", int'(sel_error), 1);
        check("multi_state", int'(state), 4);
        btns[B_CONFIRM] = 1'b0;
        @(posedge clk); #1;
        check("multi_sel_error_gone", int'(sel_error), 0);
        card_sel = 9'h000;
        press(B_CONFIRM);
        check("zero_state", int'(state), 4);
        check("zero_mask", int'(p2_mask), 'h1FF);
        card_sel = 9'h004;
        press(B_CONFIRM);
        check("p2_commit_mask", int'(p2_mask), 'h1FB);
        check("p2_commit_state", int'(state), 2);
        press(B_CONFIRM);
        check("r1_match", int'(match_result), 1);
        check("r1_p1_score", int'(p1_score), 1);
        press(B_NEXT);
        check("r2_state", int'(state), 1);
        check("r2_round", int'(round), 2);
        check("r2_hand_black", int'(p1_hand_black), 0);

        press(B_NEXT);
        press(B_P2);
        card_sel = 9'h004;
        btns[B_CONFIRM] = 1'b1;
        @(posedge clk); #1;
        check("used_sel_error", int'(sel_error), 1);
        check("used_mask", int'(p2_mask), 'h1FB);
        btns[B_CONFIRM] = 1'b0;
        @(posedge clk); #1;
        card_sel = 9'h010;
        press(B_CONFIRM);
        check("r2_p2_mask", int'(p2_mask), 'h1EB);
        pick(1, 4);
        press(B_CONFIRM);
        check("draw_match", int'(match_result), 3);
        check("draw_p1_score", int'(p1_score), 1);
        check("draw_p2_score", int'(p2_score), 0);
        press(B_NEXT);
        press(B_NEXT);
        pick(1, 5);
        press(B_P2);
        check("r3_p2_pick", int'(state), 4);
        press(B_ABORT);
        check_reset_values("abort");
        check("abort_p1_black", int'(p1_black), 4);

        // Game B: P1 reaches the win target in five rounds.
        press(B_START);
        play_round(5, 3);
        check("b1_match", int'(match_result), 1);
        check("b1_p1_score", int'(p1_score), 1);
        repeat (10) begin @(posedge clk); #1; end
        check("b1_hold_score", int'(p1_score), 1);
        check("b1_hold_state", int'(state), 5);
        press(B_NEXT);
        play_round(8, 7); press(B_NEXT);
        play_round(7, 6); press(B_NEXT);
        play_round(6, 0);
        check("b4_p1_score", int'(p1_score), 4);
        press(B_NEXT);
        play_round(4, 1);
        check("b5_p1_score", int'(p1_score), 5);
        press(B_NEXT);
        check("b_over_state", int'(state), 6);
        check("b_over_result", int'(game_result), 1);
        check("b_over_round", int'(round), 5);

        // Game C: start from GAME_OVER, then reset while in RESULT.
        press(B_START);
        check("c_state", int'(state), 1);
        check("c_round", int'(round), 1);
        check("c_game_result", int'(game_result), 0);
        check("c_mask", int'(p1_mask), 'h1FF);
        play_round(2, 1);
        check("c_result_state", int'(state), 5);
        rst = 1'b1;
        #2;
        check_reset_values("midreset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r, w;
            r = $urandom_range(99);
            if (r < 45) begin
                btns = '0;
            end else if (r < 52) begin
                btns = 6'($urandom) & 6'b111110;
            end else begin
                w = $urandom_range(199);
                btns = '0;
                if (w == 0)       btns[B_ABORT] = 1'b1;
                else if (w < 15)  btns[B_START] = 1'b1;
                else if (w < 70)  btns[B_CONFIRM] = 1'b1;
                else if (w < 120) btns[B_NEXT] = 1'b1;
                else if (w < 160) btns[B_P1] = 1'b1;
                else              btns[B_P2] = 1'b1;
            end
            if ($urandom_range(9) < 8) begin
                int k;
                k = $urandom_range(NC - 1);
                card_sel = '0;
                card_sel[k] = 1'b1;
            end else begin
                card_sel = NC'($urandom);
            end
            rst = ($urandom_range(699) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        btns = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
